// File: rtl/snake_body.sv
// Snake body tracker: ring buffer of segment cells, one-cell step with wall and
// self-collision checks, growth, and reporting of the vacated tail cell.
module snake_body #(
    parameter int         XSCREEN  = 160,
    parameter int         YSCREEN  = 120,
    parameter int         CELL     = 10,
    parameter int         MAXLEN   = 16,
    parameter int         INIT_LEN = 3,
    parameter logic [7:0] X0       = 8'd40,
    parameter logic [6:0] Y0       = 7'd60
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic       step,
    input  logic [1:0] dir,
    input  logic       grow,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    output logic [7:0] head_x,
    output logic [6:0] head_y,
    output logic [7:0] erase_x,
    output logic [6:0] erase_y,
    output logic       erase_valid,
    output logic [4:0] length,
    output logic       busy,
    output logic       done,
    output logic       dead,
    output logic [2:0] state_dbg
);

    localparam int HPW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOVE   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    // step is a request taken only in IDLE; done is a one-cycle completion pulse.
    state_t           state_q;
    logic [7:0]       buf_x_q [MAXLEN];
    logic [6:0]       buf_y_q [MAXLEN];
    logic [HPW-1:0]   hp_q;
    logic [1:0]       cur_dir_q;
    logic             grow_lat_q;
    logic             grow_eff_q;
    logic             collide_q;
    logic [4:0]       n_q;
    logic [4:0]       scan_q;
    logic [4:0]       length_q;
    logic [7:0]       cand_x_q;
    logic [6:0]       cand_y_q;
    logic [7:0]       head_x_q;
    logic [6:0]       head_y_q;
    logic [7:0]       erase_x_q;
    logic [6:0]       erase_y_q;
    logic             erase_valid_q;
    logic             done_q;
    logic             dead_q;
    logic [7:0]       rd_x_q;
    logic [6:0]       rd_y_q;

    logic [1:0]       dir_d;
    logic [7:0]       cand_x_d;
    logic [6:0]       cand_y_d;
    logic             wall_d;
    logic             grow_eff_d;
    logic [4:0]       n_d;
    logic [HPW-1:0]   hp_next;
    logic [HPW-1:0]   chk_slot;
    logic [HPW-1:0]   tail_slot;
    logic [HPW-1:0]   rd_slot;
    logic             hit;

    function automatic logic [HPW-1:0] seg_slot(input logic [HPW-1:0] p, input logic [4:0] i);
        int s;
        s = (int'(p) - int'(i)) % MAXLEN;
        if (s < 0) s = s + MAXLEN;
        return HPW'(s);
    endfunction

    always_comb begin
        // Reversal onto the neck is refused: keep going the current way.
        dir_d    = (dir == ~cur_dir_q) ? cur_dir_q : dir;
        cand_x_d = head_x_q;
        cand_y_d = head_y_q;
        wall_d   = 1'b0;
        case (dir_d)
            2'b00: begin
                wall_d   = (int'(head_x_q) + CELL) > (XSCREEN - CELL);
                cand_x_d = head_x_q + 8'(CELL);
            end
            2'b11: begin
                wall_d   = (head_x_q == 8'd0);
                cand_x_d = head_x_q - 8'(CELL);
            end
            2'b01: begin
                wall_d   = (int'(head_y_q) + CELL) > (YSCREEN - CELL);
                cand_y_d = head_y_q + 7'(CELL);
            end
            default: begin
                wall_d   = (head_y_q == 7'd0);
                cand_y_d = head_y_q - 7'(CELL);
            end
        endcase
        grow_eff_d = (grow_lat_q | grow) && (length_q < 5'(MAXLEN));
        n_d        = grow_eff_d ? length_q : length_q - 5'd1;
        hp_next    = (hp_q == HPW'(MAXLEN - 1)) ? '0 : hp_q + HPW'(1);
        chk_slot   = seg_slot(hp_q, scan_q);
        tail_slot  = seg_slot(hp_q, length_q - 5'd1);
        rd_slot    = seg_slot(hp_q, {1'b0, rd_idx});
        hit        = (buf_x_q[chk_slot] == cand_x_q) && (buf_y_q[chk_slot] == cand_y_q);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= S_IDLE;
            hp_q          <= '0;
            cur_dir_q     <= 2'b00;
            grow_lat_q    <= 1'b0;
            grow_eff_q    <= 1'b0;
            collide_q     <= 1'b0;
            n_q           <= '0;
            scan_q        <= '0;
            length_q      <= '0;
            cand_x_q      <= '0;
            cand_y_q      <= '0;
            head_x_q      <= '0;
            head_y_q      <= '0;
            erase_x_q     <= '0;
            erase_y_q     <= '0;
            erase_valid_q <= 1'b0;
            done_q        <= 1'b0;
            dead_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q       <= S_IDLE;
                hp_q          <= '0;
                cur_dir_q     <= 2'b00;
                grow_lat_q    <= 1'b0;
                collide_q     <= 1'b0;
                length_q      <= 5'(INIT_LEN);
                head_x_q      <= X0;
                head_y_q      <= Y0;
                erase_valid_q <= 1'b0;
                dead_q        <= 1'b0;
            end else begin
                grow_lat_q <= grow_lat_q | grow;
                case (state_q)
                    S_IDLE: begin
                        if (step && length_q != 5'd0) state_q <= S_MOVE;
                    end
                    S_MOVE: begin
                        // Grow is snapshotted here; later pulses belong to the next step.
                        cur_dir_q  <= dir_d;
                        cand_x_q   <= cand_x_d;
                        cand_y_q   <= cand_y_d;
                        grow_eff_q <= grow_eff_d;
                        grow_lat_q <= 1'b0;
                        n_q        <= n_d;
                        scan_q     <= '0;
                        collide_q  <= wall_d;
                        state_q    <= wall_d ? S_COMMIT : S_CHECK;
                    end
                    S_CHECK: begin
                        if (hit) begin
                            collide_q <= 1'b1;
                            state_q   <= S_COMMIT;
                        end else if (scan_q == n_q - 5'd1) begin
                            state_q <= S_COMMIT;
                        end else begin
                            scan_q <= scan_q + 5'd1;
                        end
                    end
                    S_COMMIT: begin
                        done_q <= 1'b1;
                        if (collide_q) begin
                            dead_q  <= 1'b1;
                            state_q <= S_DEAD;
                        end else begin
                            hp_q     <= hp_next;
                            head_x_q <= cand_x_q;
                            head_y_q <= cand_y_q;
                            if (grow_eff_q) begin
                                length_q      <= length_q + 5'd1;
                                erase_valid_q <= 1'b0;
                            end else begin
                                erase_x_q     <= buf_x_q[tail_slot];
                                erase_y_q     <= buf_y_q[tail_slot];
                                erase_valid_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end
                    end
                    S_DEAD: state_q <= S_DEAD;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // At full length the new head slot is the old tail slot; the tail is read before overwrite.
    always_ff @(posedge Clock) begin
        if (start) begin
            for (int i = 0; i < INIT_LEN; i++) begin
                buf_x_q[seg_slot('0, 5'(i))] <= X0 - 8'(i * CELL);
                buf_y_q[seg_slot('0, 5'(i))] <= Y0;
            end
        end else if (state_q == S_COMMIT && !collide_q) begin
            buf_x_q[hp_next] <= cand_x_q;
            buf_y_q[hp_next] <= cand_y_q;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else if ({1'b0, rd_idx} < length_q) begin
            rd_x_q <= buf_x_q[rd_slot];
            rd_y_q <= buf_y_q[rd_slot];
        end else begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end
    end

    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign head_x      = head_x_q;
    assign head_y      = head_y_q;
    assign erase_x     = erase_x_q;
    assign erase_y     = erase_y_q;
    assign erase_valid = erase_valid_q;
    assign length      = length_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign dead        = dead_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: vector tables for steps and reads, plus
// hand-written sequences for wall, self-collision, full-length and reset aborts.
module tb_snake_body;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       grow = 1'b0;
    logic [3:0] rd_idx = 4'd0;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [7:0] erase_x;
    logic [6:0] erase_y;
    logic       erase_valid;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       dead;
    logic [2:0] state_dbg;

    int checks = 0;
    int passes = 0;
    logic [36:0] exp_q[$];

    typedef struct {
        int d; int g; int hx; int hy; int len; int ev; int ex; int ey; int dd; int lat;
    } step_vec_t;

    typedef struct {
        int idx; int x; int y;
    } rd_vec_t;

    snake_body dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .step(step), .dir(dir),
        .grow(grow), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .head_x(head_x),
        .head_y(head_y), .erase_x(erase_x), .erase_y(erase_y),
        .erase_valid(erase_valid), .length(length), .busy(busy), .done(done),
        .dead(dead), .state_dbg(state_dbg)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    endtask

    function automatic logic [36:0] pk(input step_vec_t v);
        return {8'(v.hx), 7'(v.hy), 5'(v.len), 1'(v.ev), 8'(v.ex), 7'(v.ey), 1'(v.dd)};
    endfunction

    task automatic run_step(input step_vec_t v);
        logic [36:0] e;
        int cnt;
        exp_q.push_back(pk(v));
        dir  = 2'(v.d);
        grow = 1'(v.g);
        step = 1'b1;
        tick();
        step = 1'b0;
        grow = 1'b0;
        chk("busy_after_step", int'(busy), 1);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        if (done !== 1'b1) begin
            checks++;
            $display("FAIL done_timeout actual=no_done required=done within 40 cycles");
        end
        e = exp_q.pop_front();
        chk("done_latency", cnt, v.lat);
        chk("head_x", int'(head_x), int'(e[36:29]));
        chk("head_y", int'(head_y), int'(e[28:22]));
        chk("length", int'(length), int'(e[21:17]));
        chk("erase_valid", int'(erase_valid), int'(e[16]));
        if (e[16]) begin
            chk("erase_x", int'(erase_x), int'(e[15:8]));
            chk("erase_y", int'(erase_y), int'(e[7:1]));
        end
        chk("dead", int'(dead), int'(e[0]));
        chk("busy_at_done", int'(busy), int'(e[0]));
        tick();
        chk("done_pulse_end", int'(done), 0);
    endtask

    task automatic check_rd(input rd_vec_t r);
        rd_idx = 4'(r.idx);
        tick();
        chk($sformatf("rd_x[%0d]", r.idx), int'(rd_x), r.x);
        chk($sformatf("rd_y[%0d]", r.idx), int'(rd_y), r.y);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    step_vec_t tbl [4];
    rd_vec_t   rd_start [5];
    rd_vec_t   rd_after [5];
    step_vec_t v;

    initial begin
        tbl[0] = '{0, 0, 50, 60, 3, 1, 20, 60, 0, 4};
        tbl[1] = '{1, 1, 50, 70, 4, 0, 0, 0, 0, 5};
        tbl[2] = '{0, 0, 60, 70, 4, 1, 30, 60, 0, 5};
        tbl[3] = '{3, 0, 70, 70, 4, 1, 40, 60, 0, 5};
        rd_start[0] = '{0, 40, 60};
        rd_start[1] = '{1, 30, 60};
        rd_start[2] = '{2, 20, 60};
        rd_start[3] = '{3, 0, 0};
        rd_start[4] = '{15, 0, 0};
        rd_after[0] = '{0, 70, 70};
        rd_after[1] = '{1, 60, 70};
        rd_after[2] = '{2, 50, 70};
        rd_after[3] = '{3, 50, 60};
        rd_after[4] = '{4, 0, 0};

        // Reset values
        #3 Resetn = 1'b0;
        tick();
        tick();
        chk("rst_length", int'(length), 0);
        chk("rst_head_x", int'(head_x), 0);
        chk("rst_head_y", int'(head_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_erase_valid", int'(erase_valid), 0);
        chk("rst_rd_x", int'(rd_x), 0);
        Resetn = 1'b1;
        tick();

        // A step with no snake is ignored
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_len0_busy", int'(busy), 0);

        do_start();
        chk("start_length", int'(length), 3);
        chk("start_head_x", int'(head_x), 40);
        chk("start_head_y", int'(head_y), 60);
        chk("start_dead", int'(dead), 0);
        foreach (rd_start[i]) check_rd(rd_start[i]);

        foreach (tbl[i]) run_step(tbl[i]);
        foreach (rd_after[i]) check_rd(rd_after[i]);

        // March right to the last column, then into the wall
        for (int s = 1; s <= 8; s++) begin
            v = '{0, 0, 70 + 10 * s, 70, 4, 1, (s == 1) ? 50 : 30 + 10 * s, (s == 1) ? 60 : 70, 0, 5};
            run_step(v);
        end
        v = '{0, 0, 150, 70, 4, 1, 110, 70, 1, 2};
        run_step(v);
        step = 1'b1;
        repeat (3) tick();
        step = 1'b0;
        chk("dead_step_done", int'(done), 0);
        chk("dead_step_head_x", int'(head_x), 150);
        chk("dead_step_busy", int'(busy), 1);
        do_start();
        chk("restart_dead", int'(dead), 0);
        chk("restart_head_x", int'(head_x), 40);
        chk("restart_ev", int'(erase_valid), 0);
        chk("restart_busy", int'(busy), 0);

        // Grow to 5 and curl back into the body
        v = '{0, 1, 50, 60, 4, 0, 0, 0, 0, 5};  run_step(v);
        v = '{0, 1, 60, 60, 5, 0, 0, 0, 0, 6};  run_step(v);
        v = '{1, 0, 60, 70, 5, 1, 20, 60, 0, 6}; run_step(v);
        v = '{3, 0, 50, 70, 5, 1, 30, 60, 0, 6}; run_step(v);
        v = '{2, 0, 50, 70, 5, 1, 30, 60, 1, 6}; run_step(v);

        // Grow all the way to 16 cells, then one more grow at full length
        do_start();
        for (int i = 0; i < 13; i++) begin
            v = '{(i < 11) ? 0 : 1, 1, (i < 11) ? 50 + 10 * i : 150,
                  (i < 11) ? 60 : 60 + 10 * (i - 10), 4 + i, 0, 0, 0, 0, 5 + i};
            run_step(v);
        end
        v = '{1, 1, 150, 90, 16, 1, 20, 60, 0, 17};
        run_step(v);
        check_rd('{15, 30, 60});
        check_rd('{1, 150, 80});

        // Reset in the middle of CHECK
        dir  = 2'b01;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        Resetn = 1'b0;
        #1;
        chk("midrst_length", int'(length), 0);
        chk("midrst_head_x", int'(head_x), 0);
        chk("midrst_head_y", int'(head_y), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ev", int'(erase_valid), 0);
        chk("midrst_erase_x", int'(erase_x), 0);
        chk("midrst_rd_x", int'(rd_x), 0);
        chk("midrst_dead", int'(dead), 0);
        #5 Resetn = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
